// File: rtl/fsm_master_fifo_nch_if.sv
// fsm_master_fifo_nch_if: relay, transmitter and counter handshake bundle for the N-channel sequencer
interface fsm_master_fifo_nch_if #(
  parameter int N_CH = 4,
  parameter int SS_W = 3
);
  logic            rd;
  logic            we;
  logic            tx_ready;
  logic [N_CH-1:0] hitr;
  logic [N_CH-1:0] ch_en;
  logic [SS_W-1:0] ss_f;
  logic [1:0]      sel;
  logic [N_CH-1:0] en_cr;
  logic            en_cw;
  logic            clear;
  logic            read_end;
  logic            timeout_err;
  logic            busy;
  modport master (
    input  rd, we, tx_ready, hitr, ch_en,
    output ss_f, sel, en_cr, en_cw, clear, read_end, timeout_err, busy
  );
  modport slave (
    output rd, we, tx_ready, hitr, ch_en,
    input  ss_f, sel, en_cr, en_cw, clear, read_end, timeout_err, busy
  );
endinterface

// File: rtl/fsm_master_fifo_nch.sv
// fsm_master_fifo_nch: N-channel master sequencer for write broadcasts and round-robin read sweeps
module fsm_master_fifo_nch #(
  parameter int N_CH      = 4,
  parameter int SS_W      = 3,
  parameter int TO_CYCLES = 1024,
  parameter int TO_W      = 11
) (
  input logic clk,
  input logic rst,
  fsm_master_fifo_nch_if.master bus
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR, RD_REQ, RD_WAIT, DONE, ABORT} state_t;
  state_t          state, state_d;
  logic [CW-1:0]   cur, cur_d, first_idx, next_idx;
  logic [N_CH-1:0] mask, mask_d;
  logic [TO_W-1:0] to_cnt;
  logic            rd_pend, we_pend, rd_go, we_go, has_next, waiting, expired;
  assign rd_go   = state == IDLE && (bus.rd || rd_pend);
  assign we_go   = state == IDLE && !rd_go && (bus.we || we_pend);
  assign waiting = state == WR_REQ || state == WR || state == RD_REQ || state == RD_WAIT;
  assign expired = TO_CYCLES != 0 && to_cnt == TO_LAST;
  // lowest enabled channel for a new sweep, and next captured channel above cur
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.ch_en[i]) first_idx = CW'(i);
      if (mask[i] && CW'(i) > cur) begin
        next_idx = CW'(i);
        has_next = 1'b1;
      end
    end
  end
  // state, sweep position, request latches and wait-state timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur     <= '0;
      mask    <= '0;
      rd_pend <= 1'b0;
      we_pend <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_d;
      cur     <= cur_d;
      mask    <= mask_d;
      rd_pend <= rd_go ? 1'b0 : rd_pend | bus.rd;
      we_pend <= we_go ? 1'b0 : we_pend | bus.we;
      to_cnt  <= (state_d != state || !waiting) ? '0 : to_cnt + 1'b1;
    end
  end
  // next state: reads win over writes, each wait exits on its strobe or the timer
  always_comb begin
    state_d = state;
    cur_d   = cur;
    mask_d  = mask;
    case (state)
      IDLE:
        if (rd_go) begin
          mask_d  = bus.ch_en;
          cur_d   = first_idx;
          state_d = |bus.ch_en ? RD_REQ : DONE;
        end else if (we_go) state_d = WR_REQ;
      WR_REQ:  state_d = bus.tx_ready ? WR : expired ? ABORT : WR_REQ;
      WR:      state_d = bus.tx_ready ? IDLE : expired ? ABORT : WR;
      RD_REQ:  state_d = bus.tx_ready ? RD_WAIT : expired ? ABORT : RD_REQ;
      RD_WAIT:
        if (bus.hitr[cur]) begin
          state_d = has_next ? RD_REQ : DONE;
          cur_d   = has_next ? next_idx : cur;
        end else if (expired) state_d = ABORT;
      default: state_d = IDLE;
    endcase
  end
  // Moore outputs decoded from registered state and channel index
  always_comb begin
    bus.ss_f        = (state == WR_REQ || state == WR) ? '1 :
                      (state == RD_REQ || state == RD_WAIT) ? SS_W'(cur) + 1'b1 : '0;
    bus.sel         = (state == WR_REQ || state == WR) ? 2'd1 :
                      (state == RD_REQ || state == RD_WAIT) ? 2'd2 : 2'd0;
    bus.en_cr       = state == RD_WAIT ? N_CH'(1) << cur : '0;
    bus.en_cw       = state == WR;
    bus.clear       = state == DONE || state == ABORT;
    bus.read_end    = state == DONE;
    bus.timeout_err = state == ABORT;
    bus.busy        = state != IDLE;
  end
endmodule

// File: tb/tb_fsm_master_fifo_nch.sv
// tb_fsm_master_fifo_nch: scoreboard bench for the N-channel master sequencer
module tb_fsm_master_fifo_nch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];
  fsm_master_fifo_nch_if #(.N_CH(4), .SS_W(3)) bus ();
  fsm_master_fifo_nch #(.N_CH(4), .SS_W(3), .TO_CYCLES(8), .TO_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  localparam logic [12:0] WRQ = {3'd7, 2'd1, 4'd0, 4'b0000};
  localparam logic [12:0] WRV = {3'd7, 2'd1, 4'd0, 4'b1000};
  localparam logic [12:0] DN  = {3'd0, 2'd0, 4'd0, 4'b0110};
  localparam logic [12:0] AB  = {3'd0, 2'd0, 4'd0, 4'b0101};
  function automatic logic [12:0] rq(input int k);
    return {3'(k + 1), 2'd2, 4'd0, 4'b0000};
  endfunction
  function automatic logic [12:0] rw(input int k);
    return {3'(k + 1), 2'd2, 4'(1 << k), 4'b0000};
  endfunction
  function automatic logic [12:0] act();
    return {bus.ss_f, bus.sel, bus.en_cr, bus.en_cw, bus.clear, bus.read_end, bus.timeout_err};
  endfunction
  task automatic cyc(input logic r, input logic w, input logic t, input logic [3:0] h,
                     input logic [3:0] ce, input logic push, input logic [12:0] e);
    bus.rd = r;
    bus.we = w;
    bus.tx_ready = t;
    bus.hitr = h;
    bus.ch_en = ce;
    @(posedge clk);
    #1;
    if (push) exp_q.push_back(e);
    bus.rd = 1'b0;
    bus.we = 1'b0;
    bus.tx_ready = 1'b0;
    bus.hitr = '0;
  endtask
  task automatic wr_combos(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) cyc(i[3], i[0], 1'b0, {2'b00, i[2:1]}, 4'h0, 1'b1, WRV);
  endtask
  initial begin
    logic [12:0] e;
    bus.rd = 1'b0;
    bus.we = 1'b0;
    bus.tx_ready = 1'b0;
    bus.hitr = '0;
    bus.ch_en = '0;
    fork
      forever begin
        @(negedge clk);
        if (rst && bus.busy) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_busy t=%0t got=%h required=idle", $time, act());
          end else begin
            e = exp_q.pop_front();
            if (act() !== e) begin
              fails++;
              $display("FAIL outputs t=%0t got=%h required=%h", $time, act(), e);
            end
          end
        end
      end
    join_none
    #3;
    tests++;
    if ({act(), bus.busy} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%h required=0", {act(), bus.busy});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(0, 0, 0, 4'h0, 4'hF, 0, '0);
    // rd and we together: full sweep, then the latched write
    cyc(1, 1, 0, 4'h0, 4'hF, 1, rq(0));
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 4'h0, 4'hF, 1, rw(k));
      cyc(0, 0, 0, 4'(1 << k), 4'hF, 1, k == 3 ? DN : rq(k + 1));
    end
    cyc(0, 0, 0, 4'h0, 4'hF, 0, '0);
    cyc(0, 0, 0, 4'h0, 4'hF, 1, WRQ);
    cyc(0, 0, 1, 4'h0, 4'hF, 1, WRV);
    cyc(0, 0, 1, 4'h0, 4'hF, 0, '0);
    // sparse mask, foreign hitr bits ignored
    cyc(1, 0, 0, 4'h0, 4'hA, 1, rq(1));
    cyc(0, 0, 1, 4'h0, 4'hA, 1, rw(1));
    cyc(0, 0, 0, 4'h5, 4'hA, 1, rw(1));
    cyc(0, 0, 0, 4'h1, 4'hA, 1, rw(1));
    cyc(0, 0, 0, 4'h2, 4'hA, 1, rq(3));
    cyc(0, 0, 1, 4'h0, 4'hA, 1, rw(3));
    cyc(0, 0, 0, 4'h7, 4'hA, 1, rw(3));
    cyc(0, 0, 0, 4'h8, 4'hA, 1, DN);
    cyc(0, 0, 0, 4'h0, 4'hA, 0, '0);
    // empty mask goes straight to DONE
    cyc(1, 0, 0, 4'h0, 4'h0, 1, DN);
    cyc(0, 0, 0, 4'h0, 4'h0, 0, '0);
    // WR_REQ timeout with a write latched during the wait
    cyc(0, 1, 0, 4'h0, 4'h0, 1, WRQ);
    for (int k = 1; k < 8; k++) cyc(0, k == 2, 0, 4'h0, 4'h0, 1, WRQ);
    cyc(0, 0, 0, 4'h0, 4'h0, 1, AB);
    cyc(0, 0, 0, 4'h0, 4'h0, 0, '0);
    cyc(0, 0, 0, 4'h0, 4'h0, 1, WRQ);
    cyc(0, 0, 1, 4'h0, 4'h0, 1, WRV);
    cyc(0, 0, 1, 4'h0, 4'h0, 0, '0);
    // WR holds under every {rd,hitr[1:0],we} without tx_ready
    cyc(0, 1, 0, 4'h0, 4'h0, 1, WRQ);
    cyc(0, 0, 1, 4'h0, 4'h0, 1, WRV);
    wr_combos(0, 6);
    cyc(0, 0, 1, 4'h0, 4'h0, 0, '0);
    cyc(0, 0, 0, 4'h0, 4'h0, 1, WRQ);
    cyc(0, 0, 1, 4'h0, 4'h0, 1, WRV);
    wr_combos(7, 13);
    cyc(0, 0, 1, 4'h0, 4'h0, 0, '0);
    cyc(0, 0, 0, 4'h0, 4'h0, 1, DN);
    cyc(0, 0, 0, 4'h0, 4'h0, 0, '0);
    cyc(0, 0, 0, 4'h0, 4'h0, 1, WRQ);
    cyc(0, 0, 1, 4'h0, 4'h0, 1, WRV);
    wr_combos(14, 15);
    cyc(0, 0, 1, 4'h0, 4'h0, 0, '0);
    cyc(0, 0, 0, 4'h0, 4'h0, 1, DN);
    cyc(0, 0, 0, 4'h0, 4'h0, 0, '0);
    cyc(0, 0, 0, 4'h0, 4'h0, 1, WRQ);
    cyc(0, 0, 1, 4'h0, 4'h0, 1, WRV);
    cyc(0, 0, 1, 4'h0, 4'h0, 0, '0);
    // asynchronous reset in RD_WAIT with cur=2
    cyc(1, 0, 0, 4'h0, 4'hF, 1, rq(0));
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1, 4'h0, 4'hF, 1, rw(k));
      cyc(0, 0, 0, 4'(1 << k), 4'hF, 1, rq(k + 1));
    end
    cyc(0, 0, 1, 4'h0, 4'hF, 1, rw(2));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({act(), bus.busy} !== 14'd0) begin
      fails++;
      $display("FAIL async_reset got=%h required=0", {act(), bus.busy});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(0, 0, 0, 4'h0, 4'hF, 0, '0);
    tests++;
    if ({act(), bus.busy} !== 14'd0) begin
      fails++;
      $display("FAIL post_reset_idle got=%h required=0", {act(), bus.busy});
    end
    repeat (3) cyc(0, 0, 0, 4'h0, 4'hF, 0, '0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
